// File: rtl/adder_share_pkg.sv
// Shared constants and state encoding for the shared-adder arbiter.
package adder_share_pkg;
    localparam int NUM_REQ_DEF = 4;
    localparam int OP_W        = 4;
    localparam int SUM_W       = 5;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;
endpackage

// File: rtl/adder_share_arbiter_rr_pick.sv
// Round-robin first-one search: scans valid starting at ptr, wrapping around.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end
endmodule

// File: rtl/binary_adder.sv
// Plain 4-bit adder with carry-out folded into a 5-bit sum.
module binary_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [4:0] sum
);
    assign sum = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one binary_adder between NUM_REQ requesters with round-robin grant
// and a single registered, ID-tagged response slot.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = 2,
    parameter int WIDTH   = OP_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH:0]           rsp_sum,
    input  logic                     rsp_ready,
    output logic [7:0]               busy_cnt
);
    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; req_ready is one-hot and never depends on operand data.

    state_t              state, state_next;
    logic [ID_W-1:0]     ptr;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [ID_W-1:0]     win;
    logic                pick_any;
    logic                can_accept;
    logic                grant_en;
    logic [WIDTH-1:0]    sel_a, sel_b;
    logic [SUM_W-1:0]    sum;

    rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (win),
        .any   (pick_any)
    );

    assign can_accept = (state == IDLE) || rsp_ready;
    // Gating with rst_n keeps req_ready low for the whole reset window.
    assign grant_en   = can_accept && pick_any && rst_n;

    assign sel_a = req_a[win*WIDTH +: WIDTH];
    assign sel_b = req_b[win*WIDTH +: WIDTH];

    binary_adder u_add (
        .a   (sel_a),
        .b   (sel_b),
        .sum (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (grant_en)       state_next = FULL;
        else if (rsp_ready) state_next = IDLE;
    end

    always_comb begin
        req_ready = '0;
        if (grant_en) req_ready = pick_grant;
    end

    assign rsp_valid = (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            rsp_id  <= '0;
            rsp_sum <= '0;
        end else if (grant_en) begin
            ptr     <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            rsp_id  <= win;
            rsp_sum <= sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
        end else if ((req_valid != '0) && !grant_en && (busy_cnt != 8'hFF)) begin
            busy_cnt <= busy_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed and randomized bench for adder_share_arbiter against a transaction-level model.
module tb_adder_share_arbiter;
    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [W:0]     rsp_sum;
    logic           rsp_ready = 1'b0;
    logic [7:0]     busy_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] op_a [N];
    logic [W-1:0] op_b [N];

    // Reference model state
    bit m_full;
    int m_id, m_sum, m_ptr, m_busy;
    int last_win;

    adder_share_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ready (rsp_ready),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_full = 0; m_id = 0; m_sum = 0; m_ptr = 0; m_busy = 0;
    endtask

    task automatic apply_reset(input int cycles, input logic [N-1:0] v);
        @(negedge clk);
        req_valid = v;
        rst_n = 1'b0;
        #1;
        check("rsp_valid_async_reset", 32'(rsp_valid), 32'd0);
        check("req_ready_in_reset", 32'(req_ready), 32'd0);
        model_reset();
        repeat (cycles) @(negedge clk);
        check("req_ready_reset_hold", 32'(req_ready), 32'd0);
        check("busy_cnt_reset", 32'(busy_cnt), 32'd0);
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic step(input logic [N-1:0] v, input logic rr);
        int win;
        bit can;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
        end
        #1;
        can = !m_full || rr;
        win = can ? pick(v, m_ptr) : -1;
        exp_rdy = (win >= 0) ? N'(1 << win) : '0;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        last_win = win;
        if (win >= 0) begin
            m_full = 1;
            m_id   = win;
            m_sum  = int'(op_a[win]) + int'(op_b[win]);
            m_ptr  = (win + 1) % N;
        end else if (rr) begin
            m_full = 0;
        end
        if (v != 0 && win < 0 && m_busy < 255) m_busy++;
        @(posedge clk);
        #1;
        check("rsp_valid", 32'(rsp_valid), 32'(m_full));
        if (m_full) begin
            check("rsp_id", 32'(rsp_id), 32'(m_id));
            check("rsp_sum", 32'(rsp_sum), 32'(m_sum));
        end
        check("busy_cnt", 32'(busy_cnt), 32'(m_busy));
    endtask

    initial begin
        logic [N-1:0] va;
        for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; end
        model_reset();
        last_win = -1;

        // Reset with requesters already asserting valid, then idle
        apply_reset(3, 4'hF);
        step(4'b0000, 1'b1);
        check("idle_rsp_id", 32'(rsp_id), 32'd0);
        check("idle_rsp_sum", 32'(rsp_sum), 32'd0);

        // Single request from requester 1
        op_a[1] = 4'b1001; op_b[1] = 4'b1001;
        step(4'b0010, 1'b1);
        check("single_sum_const", 32'(rsp_sum), 32'b10010);
        step(4'b0000, 1'b1);

        // Round-robin with all requesters busy
        apply_reset(2, 4'h0);
        for (int i = 0; i < N; i++) begin op_a[i] = W'(i); op_b[i] = W'(i); end
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 1'b1);
            check("rr_id_const", 32'(rsp_id), 32'(k % N));
            check("rr_sum_const", 32'(rsp_sum), 32'(2 * (k % N)));
        end

        // Backpressure: held result, req2 waiting
        op_a[2] = 4'd7; op_b[2] = 4'd5;
        for (int k = 0; k < 5; k++) step(4'b0100, 1'b0);
        check("backpressure_busy", 32'(busy_cnt), 32'd5);
        step(4'b0100, 1'b1);
        check("bp_release_win", 32'(last_win), 32'd2);

        // Drain and fill in the same cycle
        op_a[3] = 4'b1111; op_b[3] = 4'b0001;
        step(4'b1000, 1'b1);
        check("fill_sum_const", 32'(rsp_sum), 32'b10000);

        // Carry boundary 15+15
        op_a[0] = 4'hF; op_b[0] = 4'hF;
        step(4'b0001, 1'b1);
        check("max_sum_const", 32'(rsp_sum), 32'd30);

        // Reset mid-operation with ptr at 2 and a result held
        op_a[1] = 4'd3; op_b[1] = 4'd4;
        step(4'b0010, 1'b1);
        step(4'b0000, 1'b0);
        apply_reset(2, 4'h0);
        step(4'b1111, 1'b1);
        check("post_reset_first_win", 32'(last_win), 32'd0);
        step(4'b0000, 1'b1);

        // Random traffic honouring the hold-until-ready contract
        va = '0;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!va[i] && $urandom_range(0, 1) == 1) begin
                    va[i]   = 1'b1;
                    op_a[i] = W'($urandom_range(0, 15));
                    op_b[i] = W'($urandom_range(0, 15));
                end
            end
            step(va, ($urandom_range(0, 3) != 0));
            if (last_win >= 0) va[last_win] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
